// File: rtl/data_mem_responder.sv
// Word-addressed data memory with byte-enable stores and a fixed-latency, in-order read pipeline.
// Define DATA_MEM_WRITE_FWD_EN to merge a same-cycle, same-word store into the read response.
module data_mem_responder #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned RD_LATENCY  = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_r_valid,
  input  logic [31:0] i_r_mem_addr,
  output logic [31:0] o_r_mem_data,
  output logic        o_r_valid,
  output logic        o_r_err,
  input  logic        i_w_en,
  input  logic [31:0] i_w_addr,
  input  logic [31:0] i_w_data,
  input  logic [3:0]  i_w_be,
  output logic [2:0]  o_inflight
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam int unsigned CW = 3;

  typedef struct packed {
    logic        valid;
    logic        err;
    logic [31:0] data;
  } rsp_t;

  logic [31:0]   mem_q [DEPTH_WORDS];
  rsp_t          pipe_q [RD_LATENCY];
  rsp_t          rsp_d;
  logic [CW-1:0] inflight_q;
  logic [CW-1:0] inflight_d;

  logic [AW-1:0] r_idx;
  logic [AW-1:0] w_idx;
  logic          r_ok;
  logic          w_ok;
  logic [31:0]   r_word;

  assign r_idx = i_r_mem_addr[AW+1:2];
  assign w_idx = i_w_addr[AW+1:2];
  assign r_ok  = (i_r_mem_addr[1:0] == 2'b00) && (i_r_mem_addr[31:AW+2] == '0);
  assign w_ok  = (i_w_addr[1:0] == 2'b00) && (i_w_addr[31:AW+2] == '0);

  // Build the response entered into the pipeline; address is ignored unless a read is requested.
  always_comb begin
    r_word = mem_q[r_idx];
`ifdef DATA_MEM_WRITE_FWD_EN
    if (i_w_en && w_ok && (w_idx == r_idx)) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (i_w_be[b]) r_word[8*b +: 8] = i_w_data[8*b +: 8];
      end
    end
`endif
    rsp_d = '0;
    if (i_r_valid) begin
      rsp_d.valid = 1'b1;
      rsp_d.err   = ~r_ok;
      rsp_d.data  = r_ok ? r_word : 32'h0;
    end
  end

  assign inflight_d = inflight_q + CW'(rsp_d.valid) - CW'(pipe_q[RD_LATENCY-1].valid);

  // Response shift register; reset drops every in-flight read.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int unsigned i = 0; i < RD_LATENCY; i++) pipe_q[i] <= '0;
      inflight_q <= '0;
    end else begin
      pipe_q[0] <= rsp_d;
      for (int unsigned i = 1; i < RD_LATENCY; i++) pipe_q[i] <= pipe_q[i-1];
      inflight_q <= inflight_d;
    end
  end

  // Storage keeps its contents through reset but ignores stores while reset is held.
  always_ff @(posedge i_clk) begin
    if (!i_rst && i_w_en && w_ok) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (i_w_be[b]) mem_q[w_idx][8*b +: 8] <= i_w_data[8*b +: 8];
      end
    end
  end

  assign o_r_valid    = pipe_q[RD_LATENCY-1].valid;
  assign o_r_err      = pipe_q[RD_LATENCY-1].err;
  assign o_r_mem_data = pipe_q[RD_LATENCY-1].data;
  assign o_inflight   = inflight_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: stimulus pushes expected responses, a negedge monitor checks them.
module tb_data_mem_responder;

  localparam int unsigned L = 2;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b0;
  logic        i_r_valid = 1'b0;
  logic [31:0] i_r_mem_addr = '0;
  logic [31:0] o_r_mem_data;
  logic        o_r_valid;
  logic        o_r_err;
  logic        i_w_en = 1'b0;
  logic [31:0] i_w_addr = '0;
  logic [31:0] i_w_data = '0;
  logic [3:0]  i_w_be = '0;
  logic [2:0]  o_inflight;

  data_mem_responder #(.DEPTH_WORDS(256), .RD_LATENCY(L)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_r_valid(i_r_valid), .i_r_mem_addr(i_r_mem_addr),
    .o_r_mem_data(o_r_mem_data), .o_r_valid(o_r_valid), .o_r_err(o_r_err),
    .i_w_en(i_w_en), .i_w_addr(i_w_addr), .i_w_data(i_w_data), .i_w_be(i_w_be),
    .o_inflight(o_inflight)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic        err;
    logic [31:0] data;
    int unsigned cyc;
  } exp_t;

  exp_t        sb_q[$];
  int unsigned cyc = 0;
  int unsigned n_chk = 0;
  int unsigned n_fail = 0;
  int unsigned peak = 0;

  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: in-flight count against the queue, response contents and timing, idle outputs zero.
  always @(negedge i_clk) begin
    if (!i_rst) begin
      int unsigned model_inf;
      exp_t e;
      model_inf = 0;
      foreach (sb_q[i]) if (sb_q[i].cyc <= cyc + L - 1) model_inf++;
      chk("inflight", 32'(o_inflight), model_inf);
      if (32'(o_inflight) > peak) peak = 32'(o_inflight);
      if (o_r_valid) begin
        if (sb_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_rsp: got data %h err %b expected no response", o_r_mem_data, o_r_err);
        end else begin
          e = sb_q.pop_front();
          chk("rsp_data", o_r_mem_data, e.data);
          chk("rsp_err", 32'(o_r_err), 32'(e.err));
          chk("rsp_cycle", cyc, e.cyc);
        end
      end else begin
        chk("idle_data", o_r_mem_data, 32'h0);
        chk("idle_err", 32'(o_r_err), 32'h0);
      end
    end
  end

  task automatic step();
    @(posedge i_clk);
    #2;
    i_r_valid    = 1'b0;
    i_r_mem_addr = $urandom;
    i_w_en       = 1'b0;
    i_w_addr     = $urandom;
    i_w_be       = 4'($urandom);
  endtask

  task automatic rd(input logic [31:0] a, input logic err, input logic [31:0] d);
    exp_t e;
    i_r_valid    = 1'b1;
    i_r_mem_addr = a;
    e.err  = err;
    e.data = d;
    e.cyc  = cyc + L;
    sb_q.push_back(e);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    i_w_en   = 1'b1;
    i_w_addr = a;
    i_w_data = d;
    i_w_be   = be;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    logic [31:0] fwd_exp;
`ifdef DATA_MEM_WRITE_FWD_EN
    fwd_exp = 32'h1122_CCDD;
`else
    fwd_exp = 32'h1122_3344;
`endif
    #1 i_rst = 1'b1;
    #1;
    chk("rst_valid", 32'(o_r_valid), 32'h0);
    chk("rst_err", 32'(o_r_err), 32'h0);
    chk("rst_data", o_r_mem_data, 32'h0);
    chk("rst_inflight", 32'(o_inflight), 32'h0);
    step(); step();

    // Read accepted on the first edge after release.
    i_rst = 1'b0;
    rd(32'h400, 1'b1, 32'h0); step();

    wr(32'h10, 32'hDEAD_BEEF, 4'hF); step();
    wr(32'h00, 32'h0101_0101, 4'hF); step();
    wr(32'h04, 32'h0202_0202, 4'hF); step();
    wr(32'h08, 32'h0303_0303, 4'hF); step();
    wr(32'h08, 32'hAABB_CCDD, 4'b1010); step();
    wr(32'h20, 32'h1122_3344, 4'hF); step();

    rd(32'h10, 1'b0, 32'hDEAD_BEEF); step();
    idle(3);

    peak = 0;
    rd(32'h00, 1'b0, 32'h0101_0101); step();
    rd(32'h04, 1'b0, 32'h0202_0202); step();
    rd(32'h08, 1'b0, 32'hAA03_CC03); step();
    idle(3);
    chk("peak_inflight", peak, 32'd2);

    rd(32'h20, 1'b0, fwd_exp);
    wr(32'h20, 32'hAABB_CCDD, 4'b0011); step();
    rd(32'h20, 1'b0, 32'h1122_CCDD); step();

    // Response is sampled at accept; the later store must not leak in.
    rd(32'h04, 1'b0, 32'h0202_0202); step();
    wr(32'h04, 32'h5566_7788, 4'hF); step();
    rd(32'h04, 1'b0, 32'h5566_7788); step();

    rd(32'h02, 1'b1, 32'h0); step();
    rd(32'h400, 1'b1, 32'h0); step();
    wr(32'h12, 32'hFFFF_FFFF, 4'hF); step();
    wr(32'h400, 32'hFFFF_FFFF, 4'hF); step();
    rd(32'h10, 1'b0, 32'hDEAD_BEEF); step();
    rd(32'h00, 1'b0, 32'h0101_0101); step();
    idle(3);

    rd(32'h00, 1'b0, 32'h0101_0101); step();
    rd(32'h04, 1'b0, 32'h5566_7788); step();
    #1 i_rst = 1'b1;
    sb_q.delete();
    #1;
    chk("midrst_valid", 32'(o_r_valid), 32'h0);
    chk("midrst_err", 32'(o_r_err), 32'h0);
    chk("midrst_data", o_r_mem_data, 32'h0);
    chk("midrst_inflight", 32'(o_inflight), 32'h0);
    wr(32'h10, 32'h0BAD_0BAD, 4'hF);
    step(); step();
    i_rst = 1'b0;
    idle(4);
    rd(32'h10, 1'b0, 32'hDEAD_BEEF); step();

    for (int i = 0; i < 20 && sb_q.size() != 0; i++) step();
    chk("drain", 32'(sb_q.size()), 32'h0);
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
